m7234_timing: RTL and testbench
===============================

M7234_TIMING -- requirements
Module: m7234_timing

Interface
REQ-001 SHALL have parameters: LEN_P1, default 4, clocks per short microcycle; LEN_P2, default 5, clocks per medium microcycle; LEN_P3, default 7, clocks per long microcycle; TMO, default 31, bus-wait timeout in clocks.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port clkl, input, 2, microword cycle-length select (0=P1, 1=P2, 2 and 3=P3).
REQ-005 SHALL have port clkoff, input, 1, microword requests a bus pause before the next upp load.
REQ-006 SHALL have port ssyn, input, 1, bus slave-sync response.
REQ-007 SHALL have port halt_req, input, 1, console halt level.
REQ-008 SHALL have port step, input, 1, single-cycle pulse, honoured only in HALT.
REQ-009 SHALL have port clk_u56_17, output, 1, one-clock strobe that loads microword fields 56:17.
REQ-010 SHALL have port clk_u16_09, output, 1, one-clock strobe that loads microword fields 16:09.
REQ-011 SHALL have port clk_upp_pupp, output, 1, one-clock strobe that loads upp[7:0] and pupp.
REQ-012 SHALL have port p_clk_upp8, output, 1, one-clock strobe that loads upp[8].
REQ-013 SHALL have port jamupp, output, 1, level that forces upp[8] and the microword registers to 0.
REQ-014 SHALL have port bus_tmo, output, 1, one-clock pulse on bus timeout.
REQ-015 SHALL have port halted, output, 1, high while in HALT.
REQ-016 SHALL have port cyc_cnt, output, 16, count of completed microcycles, wrapping.

Function
REQ-017 SHALL implement the states JAM, LATCH, RUN, BWAIT and HALT.
REQ-018 JAM SHALL assert jamupp for exactly 2 clocks and then enter LATCH.
REQ-019 LATCH SHALL last 1 clock, assert clk_u56_17 and clk_u16_09 together, and then enter RUN with phase counter = 1.
REQ-020 RUN SHALL sample clkl and clkoff on its first clock (phase 1) into a length register L and a pause flag, and hold them for the rest of the cycle.
REQ-021 RUN SHALL increment the phase each clock; at phase = L-1, with the pause flag = 0, it SHALL assert clk_upp_pupp and p_clk_upp8 for 1 clock, i.e. the cycle lasts exactly L clocks from LATCH to the upp strobe inclusive.
REQ-022 At phase = L-1 with the pause flag = 1, the block SHALL enter BWAIT and withhold the upp strobes.
REQ-023 In BWAIT, when ssyn = 1, the block SHALL issue the upp strobes on that same clock.
REQ-024 In BWAIT, after TMO clocks with ssyn = 0, the block SHALL pulse bus_tmo and issue the upp strobes on the same clock.
REQ-025 When ssyn and the timeout coincide, ssyn SHALL take priority and bus_tmo SHALL stay 0.
REQ-026 On the upp-strobe clock, cyc_cnt SHALL increment by 1 and wrap 0xFFFF -> 0x0000.
REQ-027 On the upp-strobe clock, the next state SHALL be HALT if halt_req = 1 or a step is in progress, and LATCH otherwise.
REQ-028 In HALT, halted SHALL be 1 and no strobes SHALL fire.
REQ-029 In HALT, step = 1 SHALL enter LATCH and arm a step flag; that cycle completes and returns to HALT.
REQ-030 In HALT, halt_req = 0 without step SHALL resume at LATCH.
REQ-031 A step pulse outside HALT SHALL be ignored.
REQ-032 halt_req SHALL never abort a cycle in progress; it is sampled only at the upp strobe.
REQ-033 At most one of {LATCH strobes, upp strobes} SHALL be active on any clock.
REQ-034 jamupp SHALL be 0 outside JAM.

Reset
REQ-035 reset = 1 SHALL force state = JAM, jam counter = 0, phase = 0, L = 0, pause flag = 0, step flag = 0 and cyc_cnt = 0 on the next edge, regardless of the current state.
REQ-036 While reset is high, jamupp SHALL be 1 and all other strobes, bus_tmo and halted SHALL be 0.
REQ-037 On reset release, the 2-clock JAM sequence of REQ-018 SHALL run.

Structure
REQ-038 A shared package (kd11_timing_pkg) SHALL hold the state enum, the clkl length encodings and the default LEN/TMO constants.
REQ-039 The bus timeout counter SHALL be a sub-module, m7234_tmo (load/count/expire).
REQ-040 All outputs SHALL be registered-state decodes, with no combinational path from inputs to strobes except ssyn -> upp strobes in BWAIT.

Verification
REQ-041 Release reset, clkl = 0, clkoff = 0: the bench SHALL see jamupp high for 2 clocks, LATCH strobes at t = 2, upp strobes at t = 5 and t = 9, and cyc_cnt = 2 after the second strobe.
REQ-042 clkl = 2, clkoff = 0: the bench SHALL see 7 clocks between successive LATCH strobes; clkl = 3 SHALL behave identically.
REQ-043 clkoff = 1 with ssyn raised on the 3rd BWAIT clock: the upp strobe SHALL occur on that clock and bus_tmo SHALL stay 0.
REQ-044 clkoff = 1 with ssyn = 0: bus_tmo and the upp strobes SHALL pulse together after exactly 31 BWAIT clocks, and the cycle SHALL continue.
REQ-045 halt_req raised mid-cycle: the current cycle SHALL complete and halted = 1; then two step pulses SHALL yield exactly 2 LATCH and 2 upp strobes with cyc_cnt +2; a step while running SHALL be ignored.
REQ-046 reset asserted in BWAIT: jamupp SHALL be 1 the next clock, cyc_cnt = 0, and there SHALL be no bus_tmo or upp strobe.

Source files
------------

// File: rtl/kd11_timing_pkg.sv
// Shared definitions for the KD11 microcycle timing block: state encoding,
// clkl length-select codes and default microcycle / bus-wait constants.
package kd11_timing_pkg;

    typedef enum logic [2:0] {
        ST_JAM   = 3'd0,
        ST_LATCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_BWAIT = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [1:0] CLKL_P1  = 2'd0;
    localparam logic [1:0] CLKL_P2  = 2'd1;
    localparam logic [1:0] CLKL_P3  = 2'd2;
    localparam logic [1:0] CLKL_P3B = 2'd3;

    localparam int LEN_P1_DEF = 4;
    localparam int LEN_P2_DEF = 5;
    localparam int LEN_P3_DEF = 7;
    localparam int TMO_DEF    = 31;

    localparam int LEN_W = 8;

    // Both upper clkl codes select the long microcycle.
    function automatic logic [LEN_W-1:0] sel_len(input logic [1:0] clkl,
                                                 input int p1,
                                                 input int p2,
                                                 input int p3);
        logic [LEN_W-1:0] r;
        case (clkl)
            CLKL_P1: r = LEN_W'(p1);
            CLKL_P2: r = LEN_W'(p2);
            default: r = LEN_W'(p3);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m7234_tmo.sv
// Bus-wait timeout counter: load on entry to the wait, count down while
// waiting, expire flags the final permitted wait clock.
module m7234_tmo #(
    parameter int TMO = 31
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Loaded with TMO-1 so the TMO-th wait clock sees zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TW'(TMO - 1);
        end else if (count_en && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/m7234_timing.sv
// KD11 microcycle timing generator: sequences JAM/LATCH/RUN/BWAIT/HALT and
// produces the microword and micro-PC load strobes.
module m7234_timing
    import kd11_timing_pkg::*;
#(
    parameter int LEN_P1 = LEN_P1_DEF,
    parameter int LEN_P2 = LEN_P2_DEF,
    parameter int LEN_P3 = LEN_P3_DEF,
    parameter int TMO    = TMO_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  clkl,
    input  logic        clkoff,
    input  logic        ssyn,
    input  logic        halt_req,
    input  logic        step,
    output logic        clk_u56_17,
    output logic        clk_u16_09,
    output logic        clk_upp_pupp,
    output logic        p_clk_upp8,
    output logic        jamupp,
    output logic        bus_tmo,
    output logic        halted,
    output logic [15:0] cyc_cnt
);

    state_e            state_q, state_d;
    logic              jam_q, jam_d;
    logic [LEN_W-1:0]  phase_q, phase_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              pause_q, pause_d;
    logic              step_q, step_d;
    logic [15:0]       cnt_q, cnt_d;

    logic run_last;
    logic in_bwait;
    logic tmo_expire;
    logic bwait_done;
    logic upp_fire;

    // Phase 1 is excluded because L is only valid from phase 2 onwards.
    assign run_last   = (state_q == ST_RUN) && (phase_q >= LEN_W'(2)) &&
                        (phase_q == len_q - LEN_W'(1));
    assign in_bwait   = (state_q == ST_BWAIT);
    assign bwait_done = in_bwait && (ssyn || tmo_expire);
    assign upp_fire   = (run_last && !pause_q) || bwait_done;

    m7234_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (run_last && pause_q),
        .count_en (in_bwait),
        .expire   (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        jam_d   = jam_q;
        phase_d = phase_q;
        len_d   = len_q;
        pause_d = pause_q;
        step_d  = step_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_JAM: begin
                if (jam_q) begin
                    state_d = ST_LATCH;
                    jam_d   = 1'b0;
                end else begin
                    jam_d   = 1'b1;
                end
            end
            ST_LATCH: begin
                state_d = ST_RUN;
                phase_d = LEN_W'(1);
            end
            ST_RUN: begin
                if (phase_q == LEN_W'(1)) begin
                    len_d   = sel_len(clkl, LEN_P1, LEN_P2, LEN_P3);
                    pause_d = clkoff;
                end
                phase_d = phase_q + LEN_W'(1);
                if (run_last && pause_q) begin
                    state_d = ST_BWAIT;
                end
            end
            ST_BWAIT: begin
                state_d = ST_BWAIT;
            end
            ST_HALT: begin
                if (step) begin
                    state_d = ST_LATCH;
                    step_d  = 1'b1;
                end else if (!halt_req) begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                state_d = ST_JAM;
            end
        endcase

        // halt_req is only looked at here, so a running cycle always completes.
        if (upp_fire) begin
            cnt_d = cnt_q + 16'd1;
            if (halt_req || step_q) begin
                state_d = ST_HALT;
                step_d  = 1'b0;
            end else begin
                state_d = ST_LATCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_JAM;
            jam_q   <= 1'b0;
            phase_q <= '0;
            len_q   <= '0;
            pause_q <= 1'b0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            jam_q   <= jam_d;
            phase_q <= phase_d;
            len_q   <= len_d;
            pause_q <= pause_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
        end
    end

    assign jamupp       = (state_q == ST_JAM);
    assign clk_u56_17   = (state_q == ST_LATCH);
    assign clk_u16_09   = (state_q == ST_LATCH);
    assign clk_upp_pupp = upp_fire;
    assign p_clk_upp8   = upp_fire;
    assign bus_tmo      = in_bwait && tmo_expire && !ssyn;
    assign halted       = (state_q == ST_HALT);
    assign cyc_cnt      = cnt_q;

endmodule

// File: tb/tb_m7234_timing.sv
// Directed bench for m7234_timing: reset/JAM sequence, cycle lengths, bus
// wait with ssyn and timeout, halt/step and reset during a bus wait.
module tb_m7234_timing;

    logic        clk;
    logic        reset;
    logic [1:0]  clkl;
    logic        clkoff;
    logic        ssyn;
    logic        halt_req;
    logic        step;
    logic        clk_u56_17;
    logic        clk_u16_09;
    logic        clk_upp_pupp;
    logic        p_clk_upp8;
    logic        jamupp;
    logic        bus_tmo;
    logic        halted;
    logic [15:0] cyc_cnt;

    int n_cmp = 0;
    int n_err = 0;

    m7234_timing dut (
        .clk          (clk),
        .reset        (reset),
        .clkl         (clkl),
        .clkoff       (clkoff),
        .ssyn         (ssyn),
        .halt_req     (halt_req),
        .step         (step),
        .clk_u56_17   (clk_u56_17),
        .clk_u16_09   (clk_u16_09),
        .clk_upp_pupp (clk_upp_pupp),
        .p_clk_upp8   (p_clk_upp8),
        .jamupp       (jamupp),
        .bus_tmo      (bus_tmo),
        .halted       (halted),
        .cyc_cnt      (cyc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("  ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_latch();
        int n;
        n = 0;
        while (!clk_u56_17 && n < 100) begin
            tick();
            n++;
        end
        check("latch_seen", {31'd0, clk_u56_17}, 32'd1);
    endtask

    task automatic measure_gap(output int gap);
        wait_latch();
        tick();
        gap = 1;
        while (!clk_u56_17 && gap < 100) begin
            tick();
            gap++;
        end
    endtask

    task automatic count_window(input int n, output int nl, output int nu, output int nh);
        nl = 0;
        nu = 0;
        nh = 0;
        for (int i = 0; i < n; i++) begin
            nl += int'(clk_u56_17);
            nu += int'(clk_upp_pupp);
            nh += int'(halted);
            tick();
        end
    endtask

    // {jamupp, u56_17, u16_09, upp_pupp, upp8} for t = 0..9 after reset release
    logic [4:0] exp_v [10] = '{5'b10000, 5'b10000, 5'b01100, 5'b00000, 5'b00000,
                               5'b00011, 5'b01100, 5'b00000, 5'b00000, 5'b00011};

    initial begin
        int gap;
        int nl, nu, nh;
        int tl, tu;
        logic [15:0] base;
        logic [31:0] want;

        reset    = 1'b1;
        clkl     = 2'd0;
        clkoff   = 1'b0;
        ssyn     = 1'b0;
        halt_req = 1'b0;
        step     = 1'b0;
        repeat (3) tick();

        check("rst_jamupp", {31'd0, jamupp}, 32'd1);
        check("rst_quiet", {28'd0, clk_u56_17, clk_upp_pupp, bus_tmo, halted}, 32'd0);
        check("rst_cyc_cnt", {16'd0, cyc_cnt}, 32'd0);

        // Release: JAM for 2 clocks, LATCH at t=2, upp at t=5 and t=9
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            check($sformatf("seq_t%0d", t),
                  {27'd0, jamupp, clk_u56_17, clk_u16_09, clk_upp_pupp, p_clk_upp8},
                  {27'd0, exp_v[t]});
            tick();
        end
        check("cyc_cnt_after_2", {16'd0, cyc_cnt}, 32'd2);

        // Cycle length from clkl
        clkl = 2'd2;
        measure_gap(gap);
        measure_gap(gap);
        check("gap_clkl2", gap, 32'd7);
        clkl = 2'd3;
        measure_gap(gap);
        measure_gap(gap);
        check("gap_clkl3", gap, 32'd7);
        clkl = 2'd1;
        measure_gap(gap);
        measure_gap(gap);
        check("gap_clkl1", gap, 32'd5);

        // Bus pause released by ssyn on the 3rd wait clock
        clkl   = 2'd0;
        clkoff = 1'b1;
        base   = cyc_cnt;
        repeat (3) tick();
        check("pause_withholds_upp", {31'd0, clk_upp_pupp}, 32'd0);
        repeat (3) tick();
        check("bwait3_before_ssyn", {30'd0, bus_tmo, clk_upp_pupp}, 32'd0);
        ssyn = 1'b1;
        #1;
        check("bwait3_ssyn_strobe", {29'd0, bus_tmo, clk_upp_pupp, p_clk_upp8}, 32'd3);
        tick();
        ssyn = 1'b0;
        check("ssyn_next_latch", {31'd0, clk_u56_17}, 32'd1);
        check("ssyn_cyc_cnt", {16'd0, cyc_cnt}, {16'd0, base + 16'd1});

        // Bus pause with no ssyn: timeout on the 31st wait clock
        base = cyc_cnt;
        repeat (3) tick();
        for (int k = 1; k <= 31; k++) begin
            tick();
            want = (k == 31) ? 32'd3 : 32'd0;
            check($sformatf("tmo_k%0d", k), {30'd0, bus_tmo, clk_upp_pupp}, want);
        end
        tick();
        clkoff = 1'b0;
        check("tmo_next_latch", {31'd0, clk_u56_17}, 32'd1);
        check("tmo_cyc_cnt", {16'd0, cyc_cnt}, {16'd0, base + 16'd1});

        // Halt requested mid-cycle; the cycle still completes
        tick();
        halt_req = 1'b1;
        repeat (2) tick();
        check("halt_cycle_completes", {30'd0, clk_upp_pupp, halted}, 32'd2);
        tick();
        check("halted_after_cycle", {31'd0, halted}, 32'd1);
        base = cyc_cnt;
        count_window(4, nl, nu, nh);
        check("halt_no_strobes", nl + nu, 32'd0);
        check("halt_stays", nh, 32'd4);

        // Two single steps
        tl = 0;
        tu = 0;
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            count_window(8, nl, nu, nh);
            tl += nl;
            tu += nu;
        end
        check("step_latch_count", tl, 32'd2);
        check("step_upp_count", tu, 32'd2);
        check("step_cyc_cnt", {16'd0, cyc_cnt}, {16'd0, base + 16'd2});
        check("step_back_halted", {31'd0, halted}, 32'd1);

        // Resume, then a step pulse while running must not halt
        halt_req = 1'b0;
        tick();
        check("resume_latch", {30'd0, clk_u56_17, halted}, 32'd2);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        count_window(12, nl, nu, nh);
        check("run_step_ignored", nh, 32'd0);

        // Reset during a bus wait
        wait_latch();
        clkoff = 1'b1;
        repeat (4) tick();
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("rst_bwait_no_upp", {30'd0, bus_tmo, clk_upp_pupp}, 32'd0);
        tick();
        clkoff = 1'b0;
        check("rst_bwait_jamupp", {31'd0, jamupp}, 32'd1);
        check("rst_bwait_cyc_cnt", {16'd0, cyc_cnt}, 32'd0);
        check("rst_bwait_quiet", {28'd0, bus_tmo, clk_upp_pupp, clk_u56_17, halted}, 32'd0);
        tick();
        check("rst_hold_quiet", {27'd0, jamupp, bus_tmo, clk_upp_pupp, clk_u56_17, halted}, 32'd16);
        reset = 1'b0;
        tick();
        check("rerelease_t1_jam", {30'd0, jamupp, clk_u56_17}, 32'd2);
        tick();
        check("rerelease_t2_latch", {30'd0, jamupp, clk_u56_17}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
